// File: rtl/lcd_pattern_pkg.sv
// Shared definitions for the LCD test pattern engine: pattern codes, colour
// constants, the colour-bar RGB table and the bar-width helper.
package lcd_pattern_pkg;

    typedef enum logic [2:0] {
        PAT_RED        = 3'd0,
        PAT_DIAG       = 3'd1,
        PAT_BARS       = 3'd2,
        PAT_RAMP       = 3'd3,
        PAT_CHECKER    = 3'd4,
        PAT_BORDER     = 3'd5,
        PAT_MOVING_BAR = 3'd6,
        PAT_BLACK      = 3'd7
    } pattern_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int   NUM_BARS  = 8;
    localparam int   BAR_PIXEL = 16;

    localparam rgb_t RGB_BLACK = 24'h00_00_00;
    localparam rgb_t RGB_WHITE = 24'hFF_FF_FF;
    localparam rgb_t RGB_RED   = 24'hFF_00_00;
    localparam rgb_t RGB_GREEN = 24'h00_FF_00;
    localparam rgb_t RGB_BLUE  = 24'h00_00_FF;

    // Left-to-right order of the classic colour bars.
    localparam rgb_t BAR_RGB [NUM_BARS] = '{
        24'hFF_FF_FF, 24'hFF_FF_00, 24'h00_FF_FF, 24'h00_FF_00,
        24'hFF_00_FF, 24'hFF_00_00, 24'h00_00_FF, 24'h00_00_00
    };

    function automatic int bar_width(input int h_active);
        return h_active / NUM_BARS;
    endfunction

    function automatic rgb_t bar_colour(input logic [3:0] idx);
        if (idx < 4'(NUM_BARS)) begin
            return BAR_RGB[idx[2:0]];
        end
        return RGB_BLACK;
    endfunction

endpackage

// File: rtl/test_pattern_engine_if.sv
// Video timing bundle (position, sync, enable, pattern request) as delivered
// by the LCD timing block.
interface test_pattern_engine_if;
    logic [2:0] pattern_sel;
    logic [9:0] pos_x;
    logic [8:0] pos_y;
    logic       de;
    logic       hsync;
    logic       vsync;

    modport master (output pattern_sel, pos_x, pos_y, de, hsync, vsync);
    modport slave  (input  pattern_sel, pos_x, pos_y, de, hsync, vsync);
endinterface

// File: rtl/test_pattern_engine_frame_tracker.sv
// Frame-start detection, frame counter and moving-bar position.
// Bar animation is built only when PATTERN_ANIMATION_EN is defined.
module frame_tracker
    import lcd_pattern_pkg::*;
#(
    parameter int H_ACTIVE  = 480,
    parameter int ANIM_STEP = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    test_pattern_engine_if.slave    tim,
    output logic                    frame_start,
    output logic [15:0]             frame_cnt,
    output logic [9:0]              bar_pos
);

    if (ANIM_STEP >= H_ACTIVE) begin : g_step_range
        $error("ANIM_STEP must be smaller than H_ACTIVE");
    end

    logic        vsync_prev_reg;
    logic        primed_reg;
    logic [15:0] frame_cnt_reg;

    // primed_reg masks the first sample after reset so a vsync already high
    // at release is not mistaken for a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev_reg <= 1'b0;
            primed_reg     <= 1'b0;
        end else begin
            vsync_prev_reg <= tim.vsync;
            primed_reg     <= 1'b1;
        end
    end

    assign frame_start = primed_reg & tim.vsync & ~vsync_prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
        end else if (frame_start) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_reg;

`ifdef PATTERN_ANIMATION_EN
    logic [10:0] bar_sum;
    logic [9:0]  bar_pos_reg;
    logic [9:0]  bar_pos_next;

    always_comb begin
        bar_sum      = {1'b0, bar_pos_reg} + 11'(ANIM_STEP);
        bar_pos_next = bar_sum[9:0];
        if (bar_sum >= 11'(H_ACTIVE)) begin
            bar_pos_next = 10'(bar_sum - 11'(H_ACTIVE));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_pos_reg <= '0;
        end else if (frame_start) begin
            bar_pos_reg <= bar_pos_next;
        end
    end

    assign bar_pos = bar_pos_reg;
`else
    assign bar_pos = '0;
`endif

endmodule

// File: rtl/test_pattern_engine.sv
// LCD test pattern generator with a fixed two-cycle pixel pipeline.
// Define PATTERN_ANIMATION_EN to make the pattern-6 bar move each frame.
module test_pattern_engine
    import lcd_pattern_pkg::*;
#(
    parameter int H_ACTIVE  = 480,
    parameter int V_ACTIVE  = 272,
    parameter int CHK_LOG2  = 4,
    parameter int ANIM_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  pattern_sel,
    input  logic [9:0]  pos_x,
    input  logic [8:0]  pos_y,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [15:0] frame_cnt
);

    localparam int          BAR_W     = bar_width(H_ACTIVE);
    localparam logic [10:0] H_LIMIT   = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIMIT   = 11'(V_ACTIVE);
    localparam logic [10:0] DIAG_SPAN = 11'(H_ACTIVE - V_ACTIVE);

    test_pattern_engine_if tim ();

    assign tim.pattern_sel = pattern_sel;
    assign tim.pos_x       = pos_x;
    assign tim.pos_y       = pos_y;
    assign tim.de          = de_in;
    assign tim.hsync       = hsync_in;
    assign tim.vsync       = vsync_in;

    logic       frame_start;
    logic [9:0] bar_pos;

    frame_tracker #(
        .H_ACTIVE  (H_ACTIVE),
        .ANIM_STEP (ANIM_STEP)
    ) u_frame_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .tim         (tim),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt),
        .bar_pos     (bar_pos)
    );

    // The requested pattern is latched only at frame start so a frame is
    // never split between two patterns.
    pattern_e active_pattern_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_pattern_reg <= PAT_RED;
        end else if (frame_start) begin
            active_pattern_reg <= pattern_e'(tim.pattern_sel);
        end
    end

    // Colour-bar position tracked incrementally; pos_x == 0 restarts it.
    logic [9:0] bar_cnt_reg, bar_cnt_cur, bar_cnt_next;
    logic [3:0] bar_idx_reg, bar_idx_cur, bar_idx_next;

    always_comb begin
        bar_cnt_cur = bar_cnt_reg;
        bar_idx_cur = bar_idx_reg;
        if (tim.pos_x == '0) begin
            bar_cnt_cur = '0;
            bar_idx_cur = '0;
        end
        bar_cnt_next = bar_cnt_cur + 10'd1;
        bar_idx_next = bar_idx_cur;
        if (bar_idx_cur >= 4'(NUM_BARS)) begin
            bar_cnt_next = bar_cnt_cur;
        end else if (bar_cnt_next == 10'(BAR_W)) begin
            bar_cnt_next = '0;
            bar_idx_next = bar_idx_cur + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_cnt_reg <= '0;
            bar_idx_reg <= '0;
        end else if (tim.de) begin
            bar_cnt_reg <= bar_cnt_next;
            bar_idx_reg <= bar_idx_next;
        end
    end

    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic [10:0] bar_off;
    logic        in_range;
    logic        on_border;
    rgb_t        pixel_rgb;

    always_comb begin
        x_ext     = {1'b0, tim.pos_x};
        y_ext     = {2'b0, tim.pos_y};
        // Distance right of the moving bar, folded so the bar wraps at the edge.
        bar_off   = x_ext - {1'b0, bar_pos};
        if (tim.pos_x < bar_pos) begin
            bar_off = bar_off + H_LIMIT;
        end
        in_range  = (x_ext < H_LIMIT) && (y_ext < V_LIMIT);
        on_border = (tim.pos_x == '0) || (tim.pos_x == 10'(H_ACTIVE - 1)) ||
                    (tim.pos_y == '0) || (tim.pos_y == 9'(V_ACTIVE - 1));
        pixel_rgb = RGB_BLACK;
        case (active_pattern_reg)
            PAT_RED:        pixel_rgb = RGB_RED;
            PAT_DIAG:       pixel_rgb = ((x_ext > y_ext) && (x_ext < y_ext + DIAG_SPAN))
                                        ? RGB_GREEN : RGB_BLUE;
            PAT_BARS:       pixel_rgb = bar_colour(bar_idx_cur);
            PAT_RAMP:       pixel_rgb = {tim.pos_x[7:0], tim.pos_x[7:0], tim.pos_x[7:0]};
            PAT_CHECKER:    if (tim.pos_x[CHK_LOG2] ^ tim.pos_y[CHK_LOG2]) pixel_rgb = RGB_WHITE;
            PAT_BORDER:     if (on_border) pixel_rgb = RGB_WHITE;
            PAT_MOVING_BAR: if (bar_off < 11'(BAR_PIXEL)) pixel_rgb = RGB_WHITE;
            default:        pixel_rgb = RGB_BLACK;
        endcase
        if (!in_range) begin
            pixel_rgb = RGB_BLACK;
        end
    end

    // Two-stage pipeline: stage 1 holds the raw colour, stage 2 the blanked one.
    logic [2:0]  sync_in;
    logic [2:0]  sync_s1_reg;
    logic [2:0]  sync_s2_reg;
    logic [23:0] rgb_s1_reg;
    logic [23:0] rgb_blanked;
    logic [23:0] rgb_s2_reg;

    assign sync_in = {tim.vsync, tim.hsync, tim.de};

    for (genvar gi = 0; gi < 3; gi++) begin : g_blank
        assign rgb_blanked[gi*8 +: 8] = sync_s1_reg[0] ? rgb_s1_reg[gi*8 +: 8] : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_s1_reg  <= '0;
            sync_s1_reg <= '0;
            rgb_s2_reg  <= '0;
            sync_s2_reg <= '0;
        end else begin
            rgb_s1_reg  <= pixel_rgb;
            sync_s1_reg <= sync_in;
            rgb_s2_reg  <= rgb_blanked;
            sync_s2_reg <= sync_s1_reg;
        end
    end

    assign red       = rgb_s2_reg[23:16];
    assign green     = rgb_s2_reg[15:8];
    assign blue      = rgb_s2_reg[7:0];
    assign de_out    = sync_s2_reg[0];
    assign hsync_out = sync_s2_reg[1];
    assign vsync_out = sync_s2_reg[2];

endmodule

// File: tb/tb_test_pattern_engine.sv
// Self-checking bench for test_pattern_engine: every cycle is compared with a
// behavioural model, plus a vector table and directed multi-cycle sequences.
module tb_test_pattern_engine;

    localparam int H = 480;
    localparam int V = 272;
`ifdef PATTERN_ANIMATION_EN
    localparam int ANIM = 1;
`else
    localparam int ANIM = 0;
`endif

    localparam logic [23:0] BARS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  red, green, blue;
    logic        de_out, hsync_out, vsync_out;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    test_pattern_engine_if vif ();

    test_pattern_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pattern_sel (vif.pattern_sel),
        .pos_x       (vif.pos_x),
        .pos_y       (vif.pos_y),
        .de_in       (vif.de),
        .hsync_in    (vif.hsync),
        .vsync_in    (vif.vsync),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .de_out      (de_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .frame_cnt   (frame_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int          m_pat, m_cnt, m_bar;
    bit          m_prev_vs, m_primed;
    logic [26:0] exp_prev;
    int          prev_x;
    bit          prev_de;
    logic [23:0] line_buf [H];

    typedef struct {
        int          pat;
        int          x;
        int          y;
        logic [23:0] rgb;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [23:0] model_rgb(input int pat, input int x, input int y, input int bar);
        if (x >= H || y >= V) return 24'h0;
        case (pat)
            0: return 24'hFF0000;
            1: return (x > y && x < y + (H - V)) ? 24'h00FF00 : 24'h0000FF;
            2: return (x / (H / 8) < 8) ? BARS[x / (H / 8)] : 24'h0;
            3: return {3{8'(x % 256)}};
            4: return (((x >> 4) ^ (y >> 4)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
            5: return (x == 0 || x == H - 1 || y == 0 || y == V - 1) ? 24'hFFFFFF : 24'h0;
            6: return (((x - bar + H) % H) < 16) ? 24'hFFFFFF : 24'h0;
            default: return 24'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_pat = 0; m_cnt = 0; m_bar = 0;
        m_prev_vs = 1'b0; m_primed = 1'b0;
        exp_prev = '0; prev_de = 1'b0; prev_x = 0;
    endtask

    // One pixel clock: drive inputs, advance the model, compare after the edge.
    task automatic cyc(input bit d, input bit h, input bit v, input int x, input int y, input int sel);
        logic [23:0] rgb;
        logic [26:0] exp_now;
        bit          fs;
        vif.de = d; vif.hsync = h; vif.vsync = v;
        vif.pos_x = 10'(x); vif.pos_y = 9'(y); vif.pattern_sel = 3'(sel);
        rgb     = d ? model_rgb(m_pat, x, y, m_bar) : 24'h0;
        exp_now = {rgb, d, h, v};
        fs = m_primed && v && !m_prev_vs;
        m_prev_vs = v;
        m_primed  = 1'b1;
        if (fs) begin
            m_pat = sel;
            m_cnt = (m_cnt + 1) % 65536;
            m_bar = (ANIM != 0) ? (m_bar + 4) % H : 0;
        end
        @(posedge clk);
        #1;
        check("pixel", 64'({red, green, blue, de_out, hsync_out, vsync_out}), 64'(exp_prev));
        check("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
        if (prev_de && prev_x < H) line_buf[prev_x] = {red, green, blue};
        exp_prev = exp_now;
        prev_x   = x;
        prev_de  = d;
    endtask

    task automatic vs_pulse(input int sel);
        cyc(0, 0, 0, 0, 0, sel);
        cyc(0, 0, 1, 0, 0, sel);
        cyc(0, 0, 1, 0, 0, sel);
        cyc(0, 0, 0, 0, 0, sel);
    endtask

    task automatic drive_line(input int y, input int len, input int sel);
        for (int i = 0; i < H; i++) line_buf[i] = 24'hx;
        cyc(0, 1, 0, 0, y, sel);
        cyc(0, 1, 0, 0, y, sel);
        cyc(0, 0, 0, 0, y, sel);
        for (int x = 0; x < len; x++) cyc(1, 0, 0, x, y, sel);
        cyc(0, 0, 0, 0, y, sel);
        cyc(0, 0, 0, 0, y, sel);
    endtask

    // Asynchronous reset asserted mid-cycle, held 3 edges, released after an edge.
    task automatic do_reset(input bit vs_high);
        #3 rst_n = 1'b0;
        #1;
        check("reset_async", 64'({red, green, blue, de_out, hsync_out, vsync_out, frame_cnt}), 64'h0);
        vif.vsync = vs_high; vif.de = 1'b0; vif.hsync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 64'({red, green, blue, de_out, hsync_out, vsync_out, frame_cnt}), 64'h0);
        rst_n = 1'b1;
        model_reset();
        m_prev_vs = vs_high;
    endtask

    initial begin
        vecs[0]  = '{0,  10,  10, 24'hFF0000};
        vecs[1]  = '{1, 100,  50, 24'h00FF00};
        vecs[2]  = '{1,  50, 100, 24'h0000FF};
        vecs[3]  = '{1, 300,  50, 24'h0000FF};
        vecs[4]  = '{1, 257,  50, 24'h00FF00};
        vecs[5]  = '{3, 300,   7, 24'h2C2C2C};
        vecs[6]  = '{4,   0,   0, 24'h000000};
        vecs[7]  = '{4,  16,   0, 24'hFFFFFF};
        vecs[8]  = '{4,  16,  16, 24'h000000};
        vecs[9]  = '{5,   0, 100, 24'hFFFFFF};
        vecs[10] = '{5, 479,   5, 24'hFFFFFF};
        vecs[11] = '{5,   5, 271, 24'hFFFFFF};
        vecs[12] = '{5,   5,   5, 24'h000000};
        vecs[13] = '{7,  10,  10, 24'h000000};
        vecs[14] = '{0, 480,  10, 24'h000000};
        vecs[15] = '{0,  10, 272, 24'h000000};
        vecs[16] = '{2,   0,   5, 24'hFFFFFF};
        vecs[17] = '{1,   0,   0, 24'h0000FF};

        vif.de = 0; vif.hsync = 0; vif.vsync = 0;
        vif.pos_x = 0; vif.pos_y = 0; vif.pattern_sel = 0;
        model_reset();

        #1;
        check("reset_init", 64'({red, green, blue, de_out, hsync_out, vsync_out, frame_cnt}), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pattern 0 before any frame start, then one pattern-0 frame
        drive_line(3, 40, 5);
        vs_pulse(0);
        for (int y = 0; y < 3; y++) drive_line(y, 32, 0);
        check("solid_red_px", 64'(line_buf[7]), 64'h00FF0000);
        $display("seq solid red frame done, frame_cnt=%0d", frame_cnt);

        // Table vectors, each in its own short frame
        for (int i = 0; i < 18; i++) begin
            vs_pulse(vecs[i].pat);
            cyc(1, 0, 0, vecs[i].x, vecs[i].y, vecs[i].pat);
            cyc(0, 0, 0, 0, 0, vecs[i].pat);
            check($sformatf("vec%0d", i), 64'({red, green, blue, de_out}), 64'({vecs[i].rgb, 1'b1}));
            $display("vec %0d pat=%0d (%0d,%0d) rgb=%h", i, vecs[i].pat, vecs[i].x, vecs[i].y,
                     {red, green, blue});
        end

        // Pattern request changes mid-frame; takes effect at the next vsync rise
        vs_pulse(0);
        drive_line(99, H, 0);
        drive_line(100, H, 2);
        check("midframe_hold", 64'(line_buf[60]), 64'h00FF0000);
        vs_pulse(2);
        drive_line(0, H, 2);
        check("bars_59",  64'(line_buf[59]),  64'h00FFFFFF);
        check("bars_60",  64'(line_buf[60]),  64'h00FFFF00);
        check("bars_419", 64'(line_buf[419]), 64'h000000FF);
        check("bars_420", 64'(line_buf[420]), 64'h00000000);
        check("bars_479", 64'(line_buf[479]), 64'h00000000);
        $display("seq colour bars after pattern switch done");

        // Reset mid-line, then vsync held high through release
        cyc(1, 0, 0, 0, 8, 2);
        cyc(1, 0, 0, 1, 8, 2);
        do_reset(1'b0);
        drive_line(4, 20, 3);
        check("post_reset_red", 64'(line_buf[5]), 64'h00FF0000);
        do_reset(1'b1);
        cyc(0, 0, 1, 0, 0, 4);
        cyc(0, 0, 1, 0, 0, 4);
        check("vs_high_release", 64'(frame_cnt), 64'h0);
        vs_pulse(4);
        check("first_edge", 64'(frame_cnt), 64'h1);
        $display("seq reset sequences done, frame_cnt=%0d", frame_cnt);

        // Randomized frames and lines
        for (int f = 0; f < 14; f++) begin
            vs_pulse(int'($urandom_range(0, 7)));
            for (int l = 0; l < 3; l++) begin
                drive_line(int'($urandom_range(0, 290)), int'($urandom_range(1, 500)),
                           int'($urandom_range(0, 7)));
            end
            $display("rand frame %0d pattern=%0d frame_cnt=%0d", f, m_pat, frame_cnt);
        end

        // Moving bar after 121 frames
        do_reset(1'b0);
        for (int f = 0; f < 121; f++) vs_pulse(6);
        check("frame_cnt_121", 64'(frame_cnt), 64'd121);
        drive_line(5, H, 6);
        begin
            int b;
            b = (ANIM != 0) ? 4 : 0;
            check("bar_first", 64'(line_buf[b]),                64'h00FFFFFF);
            check("bar_last",  64'(line_buf[b + 15]),           64'h00FFFFFF);
            check("bar_after", 64'(line_buf[b + 16]),           64'h00000000);
            check("bar_before", 64'(line_buf[(b + H - 1) % H]), 64'h00000000);
            $display("seq moving bar done, expected start column %0d", b);
        end
        // Keep going so an animated bar reaches the right edge and wraps
        for (int f = 0; f < 118; f++) vs_pulse(6);
        drive_line(6, H, 6);
        $display("seq bar wrap frame done, frame_cnt=%0d", frame_cnt);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
